// File: rtl/fetch_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_issue_unit
//  Description : LEGv8 instruction fetch and issue stage. Owns the program
//                counter, fetches one 32-bit word at a time from instruction
//                memory (request/valid), and issues it with its 11-bit opCode
//                to the control unit (valid/ready). On the issue handshake
//                the next PC is either pc+4 or pc+(brOffset<<2).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_W      program counter / byte-address width
//    RESET_PC  program counter value after reset
//  Build option
//    FETCH_ISSUE_COUNT_EN  when defined, issueCount counts issue handshakes
//                          (wrapping 32-bit); otherwise issueCount is 0 and
//                          no counter register exists.
//  Ports
//    clk, rstN               clock, asynchronous active-low reset
//    imemReq/imemAddr        fetch request and byte address (== pc)
//    imemValid/imemData      memory response
//    instrValid/instrReady   issue handshake
//    instr/opCode/pc         issued word, instr[31:21], its address
//    nextPc/brOffset         branch decision and word offset (issue only)
//    issueCount              number of issued instructions
// ============================================================================
module fetch_issue_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstN,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemValid,
    input  logic [31:0]     imemData,
    output logic            instrValid,
    input  logic            instrReady,
    output logic [31:0]     instr,
    output logic [10:0]     opCode,
    output logic [PC_W-1:0] pc,
    input  logic            nextPc,
    input  logic [PC_W-1:0] brOffset,
    output logic [31:0]     issueCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    logic            fetch_done;
    logic            issue_fire;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_branch;

    // Handshakes are qualified by state so stray valid/ready pulses in the
    // wrong phase are ignored.
    assign fetch_done = (state_q == S_FETCH) && imemValid;
    assign issue_fire = (state_q == S_ISSUE) && instrReady;

    // Modulo 2^PC_W arithmetic; the shift drops brOffset's top two bits,
    // which is exactly the word-to-byte conversion wrapped to PC_W.
    assign pc_seq    = pc_q + PC_W'(4);
    assign pc_branch = pc_q + (brOffset << 2);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_done) begin
                    instr_d = imemData;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_fire) begin
                    pc_d    = nextPc ? pc_branch : pc_seq;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registers, so reset drops imemReq and
    // instrValid asynchronously and no input reaches an output directly.
    // ------------------------------------------------------------------------
    assign imemReq    = (state_q == S_FETCH);
    assign instrValid = (state_q == S_ISSUE);
    assign imemAddr   = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign opCode     = instr_q[31:21];

`ifdef FETCH_ISSUE_COUNT_EN
    logic [31:0] issue_cnt_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            issue_cnt_q <= '0;
        end else if (issue_fire) begin
            issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign issueCount = issue_cnt_q;
`else
    assign issueCount = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_issue_unit.md
# fetch_issue_unit

Instruction fetch and issue stage for the LEGv8 processor. It owns the program counter, fetches 32-bit instruction words from instruction memory over a request/valid handshake, and presents each word and its 11-bit `opCode` to `ControlUnit` with a valid/ready handshake. On issue, it uses the control unit's `nextPc` decision and a sign-extended branch offset to select the next program counter.

## Interface
- `PC_W`, default 32: program counter and instruction-address width, in bits; byte addressed.
- `RESET_PC`, default 0: program counter value after reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  PC_W  fetch byte address; always equals `pc`.
- `imemValid`  in  1  instruction memory returns data this cycle.
- `imemData`  in  32  returned instruction word.
- `instrValid`  out  1  issued instruction is valid.
- `instrReady`  in  1  consumer accepts the issued instruction.
- `instr`  out  32  issued instruction word, registered.
- `opCode`  out  11  `instr[31:21]`; drives `ControlUnit.opCode`.
- `pc`  out  PC_W  address of the current or issued instruction.
- `nextPc`  in  1  branch taken, from `ControlUnit`; sampled only on an issue handshake.
- `brOffset`  in  PC_W  sign-extended word offset of the branch target.
- `issueCount`  out  32  number of issued instructions; see Configuration.

## Operation
State machine states: IDLE, FETCH, ISSUE.
- **Reset:** asynchronous. The block enters IDLE immediately. Reset values:
  - `pc` = `RESET_PC`
  - `imemReq` = 0, `instrValid` = 0
  - `instr` = 0, `opCode` = 0
  - `issueCount` = 0
- **IDLE → FETCH:** on the first rising edge after `rstN` goes high.
- **FETCH:**
  - `imemReq` = 1 and `imemAddr` = `pc`, both held stable until `imemValid` is sampled high.
  - On `imemValid` = 1, `imemData` is registered into `instr` and the state moves to ISSUE.
  - Only one request is outstanding at a time.
- **ISSUE:**
  - `instrValid` = 1 and `imemReq` = 0.
  - `instr`, `opCode` and `pc` are held stable until `instrReady` = 1.
- **Issue handshake** (`instrValid` and `instrReady` both high on an edge):
  - If `nextPc` = 1: `pc` ← `pc` + (`brOffset` << 2).
  - If `nextPc` = 0: `pc` ← `pc` + 4.
  - The state returns to FETCH and `instrValid` drops in the following cycle.
- **Arithmetic:** modulo 2^PC_W. Wrap-around is silent: `pc` = 2^PC_W−4 with no branch yields 0. Negative `brOffset` gives backward branches.
- **Ignored inputs:**
  - `imemValid` is ignored outside FETCH, and `imemData` is not captured then.
  - `instrReady` is ignored outside ISSUE.
- **Reset mid-fetch or mid-issue:** `imemReq` and `instrValid` drop asynchronously. A late `imemValid` after reset release is ignored unless the block is in FETCH. The fetch restarts at `RESET_PC`.

## Timing
- Minimum time per instruction is 2 cycles: the FETCH cycle with `imemValid` = 1, then the ISSUE cycle with `instrReady` = 1.
- Latency from `imemValid` to `instrValid` is 1 cycle.
- `imemReq` rises on the first edge after reset release.
- Back-to-back fetches: `imemReq` reasserts on the cycle after each issue handshake, with the updated `imemAddr`.
- Every memory-wait cycle and every consumer-stall cycle adds exactly 1 cycle.
- All outputs are registered or derived directly from registers. There is no combinational path from any input to any output.

## Configuration
- **`FETCH_ISSUE_COUNT_EN` defined:**
  - `issueCount` increments by 1 on every issue handshake.
  - The counter wraps from 0xFFFFFFFF to 0.
  - It clears on reset.
- **`FETCH_ISSUE_COUNT_EN` undefined:**
  - `issueCount` is constant 0.
  - No counter register is synthesized.
  - All other behaviour is identical.

## Test plan
- **Reset and first fetch:**
  - Stimulus: hold `rstN` = 0, then release.
  - Response: all outputs at their reset values while in reset; `imemReq` = 1 with `imemAddr` = 0x0 one edge after release.
- **Sequential issue:**
  - Stimulus: memory returns ADD 0x8B020020 at 0x0, then AND 0x8A020020 at 0x4; `instrReady` tied high.
  - Response: `opCode` = 11'b10001011000 with `pc` = 0x0, then `opCode` = 11'b10001010000 with `pc` = 0x4; one instruction every 2 cycles.
- **Taken branch:**
  - Stimulus: CBZ (`opCode` = 11'b10110100000) at `pc` = 0x8, with `nextPc` = 1 and `brOffset` = −2.
  - Response: next `imemAddr` = 0x0.
  - Repeat with `nextPc` = 0: next `imemAddr` = 0xC.
- **Stalls:**
  - Stimulus: delay `imemValid` by 3 cycles and hold `instrReady` low for 4 cycles.
  - Response: `imemAddr`, `instr` and `pc` stay stable throughout the stalls; exactly one issue handshake occurs.
- **Wrap-around:**
  - Stimulus: `RESET_PC` = 32'hFFFFFFFC, no branch.
  - Response: after the first issue, `imemAddr` = 0x0.
- **Mid-operation reset, with `FETCH_ISSUE_COUNT_EN` defined:**
  - Stimulus: issue 5 instructions, then assert `rstN` while in ISSUE.
  - Response: `issueCount` = 5 before reset; `instrValid`, `issueCount` and `pc` clear immediately when reset asserts.
